// File: rtl/fpu_issuer.sv
// Command-side driver for the bfloat16 fpu: credit-limited issue, fixed-latency capture, response FIFO.
// Optional build macro FPU_ISSUER_STATS_EN adds saturating op/overflow counters (stat_ops_o, stat_ovf_o).
module fpu_issuer #(
  parameter int DATA_WIDTH  = 16,
  parameter int MODE_WIDTH  = 2,
  parameter int FPU_LATENCY = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [MODE_WIDTH-1:0] cmd_mode_i,
  input  logic [DATA_WIDTH-1:0] cmd_in1_i,
  input  logic [DATA_WIDTH-1:0] cmd_in2_i,
  input  logic                  flush_i,
  output logic [MODE_WIDTH-1:0] fpu_mode_o,
  output logic [DATA_WIDTH-1:0] fpu_in1_o,
  output logic [DATA_WIDTH-1:0] fpu_in2_o,
  input  logic [DATA_WIDTH-1:0] fpu_out_i,
  input  logic                  fpu_overflow_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic                  rsp_overflow_o,
  output logic                  busy_o
`ifdef FPU_ISSUER_STATS_EN
  ,
  output logic [15:0]           stat_ops_o,
  output logic [15:0]           stat_ovf_o
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(FIFO_DEPTH + FPU_LATENCY + 2) + 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_e;

  state_e                state_q, state_d;
  logic [FPU_LATENCY:0]  vld_pipe_q;
  logic [CW-1:0]         count_q, count_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH:0]   mem_q [FIFO_DEPTH];
  logic [SW-1:0]         inflight, used;
  logic                  accept, push, pop;

  assign rsp_valid_o    = (count_q != '0);
  assign rsp_data_o     = mem_q[rd_ptr_q][DATA_WIDTH-1:0];
  assign rsp_overflow_o = mem_q[rd_ptr_q][DATA_WIDTH];
  assign busy_o         = (state_q != IDLE);

  // A pop this cycle returns its credit immediately, so a full FIFO being drained still accepts.
  always_comb begin
    inflight = '0;
    for (int i = 0; i <= FPU_LATENCY; i++) inflight = inflight + SW'(vld_pipe_q[i]);
    pop         = rsp_valid_o & rsp_ready_i;
    used        = inflight + SW'(count_q) - SW'(pop);
    cmd_ready_o = (state_q != FLUSH) & ~flush_i & (used < SW'(FIFO_DEPTH));
    accept      = cmd_valid_i & cmd_ready_o;
    push        = vld_pipe_q[FPU_LATENCY] & (state_q != FLUSH) & ~flush_i;
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    case (state_q)
      IDLE:    if (accept) state_d = ACTIVE;
      ACTIVE:  if (vld_pipe_q == '0 && count_q == '0 && !accept) state_d = IDLE;
      FLUSH:   if (vld_pipe_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) begin
      state_d  = FLUSH;
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      vld_pipe_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fpu_mode_o <= '0;
      fpu_in1_o  <= '0;
      fpu_in2_o  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      vld_pipe_q[0] <= accept;
      for (int i = 1; i <= FPU_LATENCY; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
      // Operands stay on the fpu ports between commands.
      if (accept) begin
        fpu_mode_o <= cmd_mode_i;
        fpu_in1_o  <= cmd_in1_i;
        fpu_in2_o  <= cmd_in2_i;
      end
      if (push) mem_q[wr_ptr_q] <= {fpu_overflow_i, fpu_out_i};
    end
  end

`ifdef FPU_ISSUER_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_ops_o <= '0;
      stat_ovf_o <= '0;
    end else begin
      if (accept && stat_ops_o != 16'hFFFF) stat_ops_o <= stat_ops_o + 16'd1;
      if (push && fpu_overflow_i && stat_ovf_o != 16'hFFFF) stat_ovf_o <= stat_ovf_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fpu_issuer.sv
// Bench for fpu_issuer: behavioural bfloat16 fpu stub, in-order response scoreboard, directed + random traffic.
module tb_fpu_issuer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [1:0]  cmd_mode_i = '0;
  logic [15:0] cmd_in1_i = '0;
  logic [15:0] cmd_in2_i = '0;
  logic        flush_i = 1'b0;
  logic [1:0]  fpu_mode_o;
  logic [15:0] fpu_in1_o, fpu_in2_o;
  logic [15:0] fpu_out_i;
  logic        fpu_overflow_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [15:0] rsp_data_o;
  logic        rsp_overflow_o;
  logic        busy_o;
`ifdef FPU_ISSUER_STATS_EN
  logic [15:0] stat_ops_o, stat_ovf_o;
`endif

  always #5 clk = ~clk;

  fpu_issuer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_mode_i(cmd_mode_i),
    .cmd_in1_i(cmd_in1_i), .cmd_in2_i(cmd_in2_i), .flush_i(flush_i),
    .fpu_mode_o(fpu_mode_o), .fpu_in1_o(fpu_in1_o), .fpu_in2_o(fpu_in2_o),
    .fpu_out_i(fpu_out_i), .fpu_overflow_i(fpu_overflow_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
    .rsp_overflow_o(rsp_overflow_o), .busy_o(busy_o)
`ifdef FPU_ISSUER_STATS_EN
    , .stat_ops_o(stat_ops_o), .stat_ovf_o(stat_ovf_o)
`endif
  );

  // bfloat16 <-> real for normal numbers; zero/denormal inputs treated as 0.
  function automatic real bf2r(logic [15:0] b);
    logic [63:0] bits;
    if (b[14:7] == 8'd0) return 0.0;
    bits = {b[15], 11'(b[14:7]) + 11'd896, b[6:0], 45'b0};
    return $bitstoreal(bits);
  endfunction

  function automatic logic [16:0] r2bf(real r);
    logic [63:0] bits;
    int e;
    if (r == 0.0) return 17'h0;
    bits = $realtobits(r);
    e = int'({21'b0, bits[62:52]}) - 1023 + 127;
    if (e >= 255) return {1'b1, bits[63], 8'hFF, 7'h0};
    if (e <= 0) return {1'b0, bits[63], 15'h0};
    return {1'b0, bits[63], e[7:0], bits[51:45]};
  endfunction

  function automatic logic [16:0] fpu_ref(logic [1:0] m, logic [15:0] a, logic [15:0] b);
    real x, y;
    x = bf2r(a);
    y = bf2r(b);
    case (m)
      2'd0: return r2bf(x + y);
      2'd1: return r2bf(x - y);
      2'd2: return r2bf(x * y);
      default: begin
        if (y == 0.0) return {1'b1, a[15] ^ b[15], 8'hFF, 7'h0};
        return r2bf(x / y);
      end
    endcase
  endfunction

  // fpu stub: one input register stage, combinational result from it.
  logic [33:0] fpu_reg = '0;
  logic [16:0] fpu_res;
  always @(posedge clk) fpu_reg <= {fpu_mode_o, fpu_in1_o, fpu_in2_o};
  always_comb begin
    fpu_res = fpu_ref(fpu_reg[33:32], fpu_reg[31:16], fpu_reg[15:0]);
  end
  assign fpu_out_i      = fpu_res[15:0];
  assign fpu_overflow_i = fpu_res[16];

  typedef struct {
    logic [16:0] r;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_acc = -100;
  bit   in_flush = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: called at a negedge with inputs already driven; returns at the next negedge.
  task automatic step(output logic accepted);
    logic acc, pop, ev;
    #1;
    acc = cmd_valid_i && cmd_ready_o;
    pop = rsp_valid_o && rsp_ready_i;
    if (rst_n)
      chk("cmd_ready", 32'(cmd_ready_o),
          32'(!flush_i && !in_flush && (int'(exp_q.size()) - int'(pop) < 4)));
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      in_flush = 1'b0;
      acc = 1'b0;
    end else begin
      if (pop && exp_q.size() > 0) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back('{fpu_ref(cmd_mode_i, cmd_in1_i, cmd_in2_i), cyc});
        last_acc = cyc;
      end
      if (flush_i) begin
        exp_q.delete();
        in_flush = 1'b1;
      end else if (in_flush && last_acc <= cyc - 3) begin
        in_flush = 1'b0;
      end
    end
    accepted = acc;
    @(negedge clk);
    ev = (exp_q.size() > 0) && (exp_q[0].acc <= cyc - 2);
    chk("rsp_valid", 32'(rsp_valid_o), 32'(ev));
    if (ev && rsp_valid_o) begin
      chk("rsp_data", 32'(rsp_data_o), 32'(exp_q[0].r[15:0]));
      chk("rsp_ovf", 32'(rsp_overflow_o), 32'(exp_q[0].r[16]));
    end
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(a);
  endtask

  task automatic issue(input logic [1:0] m, input logic [15:0] a, input logic [15:0] b);
    logic got;
    int   tries;
    cmd_valid_i = 1'b1; cmd_mode_i = m; cmd_in1_i = a; cmd_in2_i = b;
    got = 1'b0;
    tries = 0;
    while (!got && tries < 20) begin
      step(got);
      tries++;
    end
    if (!got) chk("issue_timeout", 32'd0, 32'd1);
    cmd_valid_i = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_valid"}, 32'(rsp_valid_o), 32'd0);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_data"}, 32'(rsp_data_o), 32'd0);
    chk({tag, "_ovf"}, 32'(rsp_overflow_o), 32'd0);
    chk({tag, "_fpu"}, 32'({fpu_mode_o, fpu_in1_o, fpu_in2_o}), 32'd0);
  endtask

  function automatic logic [15:0] rand_bf();
    logic [7:0] e;
    e = 8'($urandom_range(110, 140));
    return {1'($urandom), e, 7'($urandom)};
  endfunction

  initial begin
    logic a;
    int   n;

    // Reset state.
    rst_n = 1'b0;
    idle(2);
    check_zero_outputs("reset");
    rst_n = 1'b1;
    idle(1);

    // ADD 1.0 + 2.0, first valid seen two negedges after the accept.
    rsp_ready_i = 1'b1;
    issue(2'd0, 16'h3F80, 16'h4000);
    idle(1);
    chk("add_early", 32'(rsp_valid_o), 32'd0);
    idle(1);
    chk("add_valid", 32'(rsp_valid_o), 32'd1);
    chk("add_data", 32'(rsp_data_o), 32'h4040);
    chk("add_ovf", 32'(rsp_overflow_o), 32'd0);
    chk("fpu_hold", 32'(fpu_in1_o), 32'h3F80);
    idle(3);

    // Back-to-back MUL then ADD, responses in order.
    rsp_ready_i = 1'b0;
    issue(2'd2, 16'h4000, 16'h4040);
    issue(2'd0, 16'h3F80, 16'h3F80);
    idle(3);
    chk("order_first", 32'(rsp_data_o), 32'h40C0);
    rsp_ready_i = 1'b1;
    idle(1);
    chk("order_second", 32'(rsp_data_o), 32'h4000);
    idle(3);

    // Overflow, with fresh statistics.
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    rsp_ready_i = 1'b0;
    issue(2'd2, 16'h7F00, 16'h7F00);
    idle(2);
    chk("ovf_flag", 32'(rsp_overflow_o), 32'd1);
`ifdef FPU_ISSUER_STATS_EN
    chk("stat_ops", 32'(stat_ops_o), 32'd1);
    chk("stat_ovf", 32'(stat_ovf_o), 32'd1);
`endif
    rsp_ready_i = 1'b1;
    idle(3);

    // Back-pressure: 6 offered, 4 accepted, pop frees a credit combinationally.
    rsp_ready_i = 1'b0;
    cmd_valid_i = 1'b1;
    cmd_mode_i  = 2'd0;
    cmd_in2_i   = 16'h3F80;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      cmd_in1_i = 16'h3F80 + 16'(i);
      step(a);
      n += int'(a);
    end
    chk("bp_accepts", 32'(n), 32'd4);
    chk("bp_ready_low", 32'(cmd_ready_o), 32'd0);
    cmd_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    #1;
    chk("bp_credit", 32'(cmd_ready_o), 32'd1);
    idle(6);

    // Flush with 2 queued and 2 in flight.
    rsp_ready_i = 1'b0;
    issue(2'd0, 16'h3F80, 16'h3F80);
    issue(2'd1, 16'h4040, 16'h3F80);
    idle(2);
    issue(2'd2, 16'h4000, 16'h4000);
    issue(2'd3, 16'h4040, 16'h4000);
    flush_i = 1'b1;
    idle(1);
    flush_i = 1'b0;
    chk("flush_busy", 32'(busy_o), 32'd1);
    idle(3);
    chk("flush_idle", 32'(busy_o), 32'd0);
    chk("flush_empty", 32'(rsp_valid_o), 32'd0);
    rsp_ready_i = 1'b1;
    issue(2'd0, 16'h4000, 16'h3F80);
    idle(4);

    // Reset with 3 queued results.
    rsp_ready_i = 1'b0;
    issue(2'd0, 16'h3F80, 16'h4000);
    issue(2'd2, 16'h4000, 16'h4000);
    issue(2'd1, 16'h4040, 16'h3F80);
    idle(3);
    rst_n = 1'b0;
    idle(1);
    check_zero_outputs("midrst");
    rst_n = 1'b1;
    rsp_ready_i = 1'b1;
    idle(4);

    // Random traffic against the scoreboard.
    for (int i = 0; i < 400; i++) begin
      cmd_valid_i = ($urandom_range(0, 3) != 0);
      cmd_mode_i  = 2'($urandom);
      cmd_in1_i   = rand_bf();
      cmd_in2_i   = rand_bf();
      rsp_ready_i = ($urandom_range(0, 3) != 0);
      flush_i     = ($urandom_range(0, 49) == 0);
      step(a);
    end
    cmd_valid_i = 1'b0;
    flush_i     = 1'b0;
    rsp_ready_i = 1'b1;
    idle(8);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
